// File: rtl/multiplier_booth_seq_if.sv
// Request/response bundle between the execute stage and the sequential Booth multiplier.
interface multiplier_booth_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic                startE;
    logic                flush;
    logic [1:0]          mul_opcode;
    logic [XLEN-1:0]     operand1;
    logic [XLEN-1:0]     operand2;
    logic [XLEN-1:0]     result;
    logic [2*XLEN-1:0]   result_multiply;
    logic                busy;
    logic                ready;

    modport master (
        output startE, flush, mul_opcode, operand1, operand2,
        input  result, result_multiply, busy, ready
    );

    modport slave (
        input  startE, flush, mul_opcode, operand1, operand2,
        output result, result_multiply, busy, ready
    );
endinterface

// File: rtl/multiplier_booth_seq.sv
// Iterative radix-4 Booth multiplier for MUL/MULH/MULHSU/MULHU, two multiplier bits per cycle.
// Result registers hold until the next completion; flush aborts an in-flight operation.
module multiplier_booth_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multiplier_booth_seq_if.slave   bus
);
    localparam int unsigned ITER = (XLEN + 2) / 2;
    localparam int unsigned W    = XLEN + 2;
    localparam int unsigned AW   = W + 2;
    localparam int unsigned CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              accept_c;
    logic              last_c;

    logic [1:0]        op_q;
    logic [W-1:0]      m_q;
    logic [W-1:0]      q_q;
    logic              qm1_q;
    logic [AW-1:0]     acc_q;
    logic [CW-1:0]     cnt_q;

    logic [XLEN-1:0]   result_q;
    logic [2*XLEN-1:0] result_multiply_q;
    logic              busy_q;
    logic              ready_q;

    logic              sign1_c;
    logic              sign2_c;
    logic [W-1:0]      ext1_c;
    logic [W-1:0]      ext2_c;
    logic [AW-1:0]     m_ext_c;
    logic [AW-1:0]     m2_c;
    logic [AW-1:0]     term_c;
    logic [AW-1:0]     acc_sum_c;
    logic [AW-1:0]     acc_nxt_c;
    logic [W-1:0]      q_nxt_c;
    logic [2*XLEN-1:0] prod_c;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush always wins over a new request
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        last_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.startE && !bus.flush) begin
                    accept_c  = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (cnt_q == CW'(ITER - 1)) begin
                    last_c    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.startE && !bus.flush) begin
                    accept_c  = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand extension and one radix-4 Booth step
    always_comb begin
        sign1_c   = (bus.mul_opcode != 2'b11);
        sign2_c   = (bus.mul_opcode[1] == 1'b0);
        ext1_c    = {{2{sign1_c & bus.operand1[XLEN-1]}}, bus.operand1};
        ext2_c    = {{2{sign2_c & bus.operand2[XLEN-1]}}, bus.operand2};
        m_ext_c   = {{2{m_q[W-1]}}, m_q};
        m2_c      = {m_ext_c[AW-2:0], 1'b0};
        term_c    = '0;
        case ({q_q[1:0], qm1_q})
            3'b001, 3'b010: term_c = m_ext_c;
            3'b011:         term_c = m2_c;
            3'b100:         term_c = ~m2_c + AW'(1);
            3'b101, 3'b110: term_c = ~m_ext_c + AW'(1);
            default:        term_c = '0;
        endcase
        acc_sum_c = acc_q + term_c;
        acc_nxt_c = {{2{acc_sum_c[AW-1]}}, acc_sum_c[AW-1:2]};
        q_nxt_c   = {acc_sum_c[1:0], q_q[W-1:2]};
        prod_c    = {acc_nxt_c[XLEN-3:0], q_nxt_c};
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q              <= '0;
            m_q               <= '0;
            q_q               <= '0;
            qm1_q             <= 1'b0;
            acc_q             <= '0;
            cnt_q             <= '0;
            result_q          <= '0;
            result_multiply_q <= '0;
            busy_q            <= 1'b0;
            ready_q           <= 1'b0;
        end else begin
            busy_q  <= (state_nxt == BUSY);
            ready_q <= (state_nxt == DONE);
            if (accept_c) begin
                op_q  <= bus.mul_opcode;
                m_q   <= ext1_c;
                q_q   <= ext2_c;
                qm1_q <= 1'b0;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (state == BUSY && !bus.flush) begin
                acc_q <= acc_nxt_c;
                q_q   <= q_nxt_c;
                qm1_q <= q_q[1];
                cnt_q <= cnt_q + CW'(1);
            end
            if (last_c) begin
                result_multiply_q <= prod_c;
                result_q          <= (op_q == 2'b00) ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
            end
        end
    end

    assign bus.result          = result_q;
    assign bus.result_multiply = result_multiply_q;
    assign bus.busy            = busy_q;
    assign bus.ready           = ready_q;

endmodule

// File: tb/tb_multiplier_booth_seq.sv
// Bench for multiplier_booth_seq: directed corner cases plus random operations against a wide-integer product model.
module tb_multiplier_booth_seq;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ITER = (XLEN + 2) / 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiplier_booth_seq_if #(.XLEN(XLEN)) bus ();
    multiplier_booth_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_res  = '0;
    logic [63:0] exp_full = '0;

    // Exact product of the extended operands, truncated to 64 bits
    function automatic logic [63:0] model_full(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [67:0] ea;
        logic signed [67:0] eb;
        logic signed [67:0] p;
        ea = (op != 2'b11)   ? {{36{a[31]}}, a} : {36'd0, a};
        eb = (op[1] == 1'b0) ? {{36{b[31]}}, b} : {36'd0, b};
        p  = ea * eb;
        return p[63:0];
    endfunction

    function automatic logic [31:0] model_res(input logic [1:0] op, input logic [63:0] full);
        return (op == 2'b00) ? full[31:0] : full[63:32];
    endfunction

    task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.startE     = 1'b1;
        bus.mul_opcode = op;
        bus.operand1   = a;
        bus.operand2   = b;
        @(negedge clk);
        bus.startE     = 1'b0;
        bus.mul_opcode = 2'($urandom);
        bus.operand1   = $urandom;
        bus.operand2   = $urandom;
    endtask

    // Waits for ready (counting cycles since accept), optionally pulsing startE mid-BUSY
    task automatic wait_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int pulse_at);
        int n = 1;
        int busy_n = 0;
        logic [63:0] f;
        f = model_full(op, a, b);
        while (bus.ready !== 1'b1 && n < 100) begin
            if (bus.busy === 1'b1) busy_n++;
            if (pulse_at != 0 && n == pulse_at) begin
                bus.startE   = 1'b1;
                bus.operand1 = $urandom;
                bus.operand2 = $urandom;
            end else if (pulse_at != 0 && n == pulse_at + 1) begin
                bus.startE = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        check(tag, "latency", 64'(n), 64'(ITER + 1));
        check(tag, "busy_cycles", 64'(busy_n), 64'(ITER));
        check(tag, "result", 64'(bus.result), 64'(model_res(op, f)));
        check(tag, "result_multiply", bus.result_multiply, f);
        exp_full = f;
        exp_res  = model_res(op, f);
    endtask

    task automatic quiet_window(input string tag, input int cycles);
        int rdy_n = 0;
        int bsy_n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.ready === 1'b1) rdy_n++;
            if (bus.busy === 1'b1) bsy_n++;
        end
        check(tag, "no_ready", 64'(rdy_n), 64'd0);
        check(tag, "no_busy", 64'(bsy_n), 64'd0);
    endtask

    initial begin
        logic [31:0] corners [6];
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0000_0002;

        rst = 1'b1;
        bus.startE = 1'b0; bus.flush = 1'b0; bus.mul_opcode = 2'b00;
        bus.operand1 = '0; bus.operand2 = '0;
        repeat (2) @(negedge clk);
        check("reset", "result", 64'(bus.result), 64'd0);
        check("reset", "result_multiply", bus.result_multiply, 64'd0);
        check("reset", "busy", 64'(bus.busy), 64'd0);
        check("reset", "ready", 64'(bus.ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors
        issue(2'b00, 32'd7, 32'hFFFF_FFFD);
        wait_check("mul_neg", 2'b00, 32'd7, 32'hFFFF_FFFD, 0);
        check("mul_neg", "const", bus.result_multiply, 64'hFFFF_FFFF_FFFF_FFEB);
        issue(2'b00, 32'd3, 32'd5);                         // back-to-back from DONE
        wait_check("b2b", 2'b00, 32'd3, 32'd5, 0);
        check("b2b", "const", 64'(bus.result), 64'h0000_000F);
        @(negedge clk);
        check("after_done", "ready", 64'(bus.ready), 64'd0);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000);
        wait_check("mulh", 2'b01, 32'h8000_0000, 32'h8000_0000, 0);
        issue(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_check("mulhu", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_check("mulhsu", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        issue(2'b10, 32'h0000_0002, 32'h8000_0000);
        wait_check("mulhsu2", 2'b10, 32'h0000_0002, 32'h8000_0000, 0);
        check("mulhsu2", "const", 64'(bus.result), 64'h0000_0001);

        // startE pulsed mid-BUSY is ignored
        @(negedge clk);
        issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        wait_check("ignore", 2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 5);
        quiet_window("ignore", 20);

        // flush in the 5th BUSY cycle
        issue(2'b00, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (4) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush", "busy", 64'(bus.busy), 64'd0);
        quiet_window("flush", 25);
        check("flush", "result_kept", 64'(bus.result), 64'(exp_res));
        check("flush", "full_kept", bus.result_multiply, exp_full);

        // flush together with startE in IDLE and in DONE suppresses the start
        bus.flush = 1'b1;
        issue(2'b11, 32'd9, 32'd9);
        bus.flush = 1'b0;
        check("flush_idle", "busy", 64'(bus.busy), 64'd0);
        issue(2'b11, 32'd9, 32'd9);
        wait_check("pre_done_flush", 2'b11, 32'd9, 32'd9, 0);
        bus.flush = 1'b1;
        issue(2'b00, 32'd4, 32'd4);
        bus.flush = 1'b0;
        check("flush_done", "busy", 64'(bus.busy), 64'd0);
        quiet_window("flush_done", 5);

        // asynchronous reset mid-BUSY
        issue(2'b01, 32'hFFFF_0000, 32'h0001_FFFF);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst", "result", 64'(bus.result), 64'd0);
        check("async_rst", "result_multiply", bus.result_multiply, 64'd0);
        check("async_rst", "busy", 64'(bus.busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(2'b00, 32'd2, 32'd2);
        wait_check("post_rst", 2'b00, 32'd2, 32'd2, 0);
        check("post_rst", "const", 64'(bus.result), 64'd4);

        // Random operations, mixed with corner operands and idle gaps
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom);
            ra  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            issue(rop, ra, rb);
            wait_check("random", rop, ra, rb, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/multiplier_booth_seq.md
Name: multiplier_booth_seq

Overview:
Iterative radix-4 Booth multiplier for the RV32M multiply group (MUL, MULH, MULHSU, MULHU), parametrised in operand width.
- Sits in the execute stage beside the ALU.
- Processes two multiplier bits per cycle.
- Holds its result until the pipeline consumes it.
- Successor to the single-width radix-2 unit. Adds: all four opcodes start the engine (MUL included), a configurable width, a flush abort, a busy flag, and a selected XLEN-bit result alongside the full product.

Parameters:
- XLEN, 32, operand width in bits; must be even and ≥ 4.
- ITER, (XLEN+2)/2, number of radix-4 iteration cycles; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- startE  input  1  request to begin a multiply; sampled only in IDLE or DONE.
- flush  input  1  abort the in-flight operation (pipeline kill).
- mul_opcode  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; latched with startE.
- operand1  input  XLEN  rs1 value; latched with startE.
- operand2  input  XLEN  rs2 value; latched with startE.
- result  output  XLEN  product[XLEN-1:0] for MUL; product[2XLEN-1:XLEN] for all other opcodes.
- result_multiply  output  2*XLEN  full product.
- busy  output  1  high while in BUSY.
- ready  output  1  one-cycle pulse: result and result_multiply valid.

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - result, result_multiply, busy and ready all 0.
  - Internal accumulator, multiplicand, multiplier and counter registers cleared.
- Operand extension to XLEN+2 bits at accept:
  - operand1 is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - operand2 is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
- Arithmetic:
  - Exact two's-complement product of the extended operands, truncated to 2*XLEN bits.
  - The accumulator is internally wide enough that no overflow occurs, including when the 2M recoding term is applied.
- Booth recoding, each BUSY cycle:
  - Examine the multiplier triplet {q[1], q[0], q[-1]}. q[-1] = 0 at start.
  - Add 0, +M, +2M, -M or -2M to the upper accumulator.
  - Then arithmetic-shift {acc, q} right by 2.
- FSM states and transitions:
  - IDLE: startE=1 → latch operands and opcode, clear accumulator, counter = 0, go to BUSY. Otherwise stay.
  - BUSY: busy=1. Perform one iteration per cycle. counter increments; when counter == ITER-1 on the current cycle, go to DONE next cycle.
  - DONE: ready=1 for exactly this cycle; register result and result_multiply on entry. startE=1 → accept the new operation and go to BUSY (back-to-back). Otherwise go to IDLE.
- Latency:
  - startE sampled at edge N → ready high in cycle N+ITER+1.
  - XLEN=32: ITER=17, so ready arrives 18 cycles after accept.
  - Throughput: one operation per ITER+1 cycles.
- Outputs hold their last value outside DONE until the next completion or reset.
- startE while in BUSY is ignored. There is no queueing; the requester must wait for ready.
- flush:
  - BUSY with flush=1 → IDLE next cycle. No ready pulse; outputs keep their previous values.
  - flush in IDLE or DONE has no effect on outputs, but any startE in the same cycle is suppressed.
  - flush wins over startE.
- Reset during BUSY returns immediately to IDLE with all outputs 0. No ready is generated for the aborted operation.
- Changes on mul_opcode or operands after accept do not affect the in-flight operation.

Test Plan:
- MUL, 7 × 0xFFFFFFFD (-3) → ready 18 cycles after accept; result = 0xFFFFFFEB; result_multiply = 0xFFFFFFFF_FFFFFFEB.
- MULH, 0x80000000 × 0x80000000 → result = 0x40000000; result_multiply = 0x40000000_00000000.
- MULHU, 0xFFFFFFFF × 0xFFFFFFFF → result = 0xFFFFFFFE; result_multiply = 0xFFFFFFFE_00000001.
- MULHSU, 0xFFFFFFFF × 0xFFFFFFFF → result = 0xFFFFFFFF; result_multiply = 0xFFFFFFFF_00000001. Then MULHSU 0x00000002 × 0x80000000 → result = 0x00000001.
- Back-to-back and ignore checks:
  - startE asserted in the DONE cycle with MUL 3 × 5 → second ready exactly 18 cycles later, result = 0x0000000F.
  - startE pulsed mid-BUSY is ignored: busy profile unchanged, no extra ready.
- Abort checks:
  - flush in the 5th BUSY cycle → IDLE next cycle, no ready, result unchanged.
  - rst asserted asynchronously mid-BUSY → outputs 0 immediately; a fresh MUL 2 × 2 then yields 4.
